// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction-register, flag and memory handshake bundle
// between the RV32I multicycle datapath (master) and its controller (slave).
`default_nettype none

interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             zero;
    logic             lt;
    logic             ltu;
    logic             mem_ready;

    logic             mem_req;
    logic             adrsrc;
    logic             irwrite;
    logic             pcwrite;
    logic             memwrite;
    logic             regwrite;
    logic [1:0]       resultsrc;
    logic [1:0]       alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       aluop;
    logic [2:0]       immsrc;
    logic [CNT_W-1:0] instret;
    logic             illegal;

    modport master (
        output op, funct3, zero, lt, ltu, mem_ready,
        input  mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite,
               resultsrc, alusrca, alusrcb, aluop, immsrc, instret, illegal
    );

    modport slave (
        input  op, funct3, zero, lt, ltu, mem_ready,
        output mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite,
               resultsrc, alusrca, alusrcb, aluop, immsrc, instret, illegal
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle Moore control FSM with branch evaluation and
// retired-instruction counter. Optional macro ILLEGAL_TRAP_EN makes bad opcodes trap.
`default_nettype none

module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  wire                clk,
    input  wire                rst_n,
    multicycle_ctrl_if.slave   bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_LUI, S_AUIPC, S_ALUWB, S_JAL, S_BRANCH, S_ILLEGAL
    } state_t;

    state_t           state_q, state_d;
    logic             mem_req_q, adrsrc_q, memwrite_q, regwrite_q;
    logic             fetch_q, jal_q, branch_q;
    logic [1:0]       resultsrc_q, alusrca_q, alusrcb_q, aluop_q;
    logic [CNT_W-1:0] instret_q;
    logic             retire_w, taken_w;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b0110111:             state_d = S_LUI;
                    7'b0010111:             state_d = S_AUIPC;
                    default:                state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH:             state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_ILLEGAL:  state_d = S_ILLEGAL;
`else
            S_ILLEGAL:  state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (bus.funct3)
            3'b000:  taken_w = bus.zero;
            3'b001:  taken_w = !bus.zero;
            3'b100:  taken_w = bus.lt;
            3'b101:  taken_w = !bus.lt;
            3'b110:  taken_w = bus.ltu;
            3'b111:  taken_w = !bus.ltu;
            default: taken_w = 1'b0;
        endcase
    end

    assign retire_w = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                      ((state_q == S_MEMWRITE) && bus.mem_ready);

    // Moore outputs are registered from the next state so they are valid on state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            instret_q   <= '0;
            mem_req_q   <= 1'b1;
            adrsrc_q    <= 1'b0;
            memwrite_q  <= 1'b0;
            regwrite_q  <= 1'b0;
            fetch_q     <= 1'b1;
            jal_q       <= 1'b0;
            branch_q    <= 1'b0;
            resultsrc_q <= 2'b10;
            alusrca_q   <= 2'b00;
            alusrcb_q   <= 2'b10;
            aluop_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            if (retire_w) instret_q <= instret_q + CNT_W'(1);
            mem_req_q   <= 1'b0;
            adrsrc_q    <= 1'b0;
            memwrite_q  <= 1'b0;
            regwrite_q  <= 1'b0;
            fetch_q     <= 1'b0;
            jal_q       <= 1'b0;
            branch_q    <= 1'b0;
            resultsrc_q <= 2'b00;
            alusrca_q   <= 2'b00;
            alusrcb_q   <= 2'b00;
            aluop_q     <= 2'b00;
            case (state_d)
                S_FETCH: begin
                    mem_req_q <= 1'b1; fetch_q <= 1'b1;
                    resultsrc_q <= 2'b10; alusrcb_q <= 2'b10;
                end
                S_DECODE:   begin alusrca_q <= 2'b01; alusrcb_q <= 2'b01; end
                S_MEMADR:   begin alusrca_q <= 2'b10; alusrcb_q <= 2'b01; end
                S_MEMREAD:  begin mem_req_q <= 1'b1; adrsrc_q <= 1'b1; end
                S_MEMWB:    begin resultsrc_q <= 2'b01; regwrite_q <= 1'b1; end
                S_MEMWRITE: begin mem_req_q <= 1'b1; adrsrc_q <= 1'b1; memwrite_q <= 1'b1; end
                S_EXECR:    begin alusrca_q <= 2'b10; aluop_q <= 2'b10; end
                S_EXECI:    begin alusrca_q <= 2'b10; alusrcb_q <= 2'b01; aluop_q <= 2'b10; end
                S_LUI:      begin alusrca_q <= 2'b11; alusrcb_q <= 2'b01; end
                S_AUIPC:    begin alusrca_q <= 2'b01; alusrcb_q <= 2'b01; end
                S_ALUWB:    regwrite_q <= 1'b1;
                S_JAL:      begin alusrca_q <= 2'b01; alusrcb_q <= 2'b10; jal_q <= 1'b1; end
                S_BRANCH: begin
                    alusrca_q <= 2'b10; aluop_q <= 2'b01; branch_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      illegal_q <= 1'b0;
        else if (state_d == S_ILLEGAL)   illegal_q <= 1'b1;
    end
    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    always_comb begin
        case (bus.op)
            7'b0000011, 7'b0010011: bus.immsrc = 3'b000;
            7'b0100011:             bus.immsrc = 3'b001;
            7'b1100011:             bus.immsrc = 3'b010;
            7'b1101111:             bus.immsrc = 3'b011;
            7'b0110111, 7'b0010111: bus.immsrc = 3'b100;
            default:                bus.immsrc = 3'b000;
        endcase
    end

    // Handshake-dependent strobes stay combinational; rst_n gating keeps them low in reset.
    assign bus.irwrite   = rst_n && fetch_q && bus.mem_ready;
    assign bus.pcwrite   = rst_n && ((fetch_q && bus.mem_ready) || jal_q || (branch_q && taken_w));
    assign bus.mem_req   = mem_req_q;
    assign bus.adrsrc    = adrsrc_q;
    assign bus.memwrite  = memwrite_q;
    assign bus.regwrite  = regwrite_q;
    assign bus.resultsrc = resultsrc_q;
    assign bus.alusrca   = alusrca_q;
    assign bus.alusrcb   = alusrcb_q;
    assign bus.aluop     = aluop_q;
    assign bus.instret   = instret_q;
endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-instruction phase-sequence reference model with randomized
// wait states, flags and opcodes; CNT_W=4 so the counter wrap is reachable.
`default_nettype none

module tb_multicycle_ctrl;
    localparam int CW = 4;
    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5, P_XR = 6;
    localparam int P_XI = 7, P_LUI = 8, P_AUI = 9, P_AWB = 10, P_JAL = 11, P_BR = 12, P_ILL = 13;

    logic clk, rst_n;
    int checks, failures;
    logic [CW-1:0] exp_instret;

    multicycle_ctrl_if #(.CNT_W(CW)) bus ();
    multicycle_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'h03, 7'h13: return 3'd0;
            7'h23:        return 3'd1;
            7'h63:        return 3'd2;
            7'h6F:        return 3'd3;
            7'h37, 7'h17: return 3'd4;
            default:      return 3'd0;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z, l, lu);
        case (f3)
            3'd0: return z;   3'd1: return !z;
            3'd4: return l;   3'd5: return !l;
            3'd6: return lu;  3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    // {mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite, resultsrc, alusrca, alusrcb, aluop, immsrc, illegal}
    function automatic logic [17:0] exp_vec(input int ph, input logic mr, input logic [6:0] op,
                                            input logic [2:0] f3, input logic z, l, lu, input logic ill);
        logic mq, ad, irw, pcw, mw, rw;
        logic [1:0] rs, a, b, alu;
        {mq, ad, irw, pcw, mw, rw} = '0;
        {rs, a, b, alu} = '0;
        case (ph)
            P_F:   begin mq = 1; irw = mr; pcw = mr; rs = 2; b = 2; end
            P_D:   begin a = 1; b = 1; end
            P_MA:  begin a = 2; b = 1; end
            P_MR:  begin mq = 1; ad = 1; end
            P_MWB: begin rs = 1; rw = 1; end
            P_MW:  begin mq = 1; ad = 1; mw = 1; end
            P_XR:  begin a = 2; alu = 2; end
            P_XI:  begin a = 2; b = 1; alu = 2; end
            P_LUI: begin a = 3; b = 1; end
            P_AUI: begin a = 1; b = 1; end
            P_AWB: rw = 1;
            P_JAL: begin a = 1; b = 2; pcw = 1; end
            P_BR:  begin a = 2; alu = 1; pcw = br_taken(f3, z, l, lu); end
            default: ;
        endcase
        return {mq, ad, irw, pcw, mw, rw, rs, a, b, alu, imm_of(op), ill};
    endfunction

    function automatic logic [17:0] act_vec();
        return {bus.mem_req, bus.adrsrc, bus.irwrite, bus.pcwrite, bus.memwrite, bus.regwrite,
                bus.resultsrc, bus.alusrca, bus.alusrcb, bus.aluop, bus.immsrc, bus.illegal};
    endfunction

    task automatic do_reset();
        logic [17:0] e;
        @(negedge clk);
        bus.op = 7'h33; bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        exp_instret = '0;
        #1;
        e = exp_vec(P_F, 1'b0, bus.op, bus.funct3, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act_vec() !== e) begin
            failures++; $display("FAIL reset_outputs actual=%h required=%h", act_vec(), e);
        end
        checks++;
        if (bus.instret !== exp_instret) begin
            failures++; $display("FAIL reset_instret actual=%0d required=%0d", bus.instret, exp_instret);
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic one_cycle(input int ph, input logic mr, input logic [6:0] op, input logic [2:0] f3,
                             input logic z, l, lu, input logic ill);
        logic [17:0] e;
        @(negedge clk);
        bus.op = op; bus.funct3 = f3; bus.zero = z; bus.lt = l; bus.ltu = lu; bus.mem_ready = mr;
        #1;
        e = exp_vec(ph, mr, op, f3, z, l, lu, ill);
        checks++;
        if (act_vec() !== e) begin
            failures++;
            $display("FAIL outputs op=%h f3=%0d phase=%0d actual=%h required=%h", op, f3, ph, act_vec(), e);
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int wf, input int wm,
                             input logic z, l, lu);
        int seq[$];
        bit retires;
        retires = 1'b1;
        seq = '{P_F, P_D};
        case (op)
            7'h03: seq = {seq, P_MA, P_MR, P_MWB};
            7'h23: seq = {seq, P_MA, P_MW};
            7'h33: seq = {seq, P_XR, P_AWB};
            7'h13: seq = {seq, P_XI, P_AWB};
            7'h63: seq.push_back(P_BR);
            7'h6F: seq = {seq, P_JAL, P_AWB};
            7'h37: seq = {seq, P_LUI, P_AWB};
            7'h17: seq = {seq, P_AUI, P_AWB};
            default: begin seq.push_back(P_ILL); retires = 1'b0; end
        endcase
        foreach (seq[i]) begin
            if (seq[i] == P_F || seq[i] == P_MR || seq[i] == P_MW) begin
                int w;
                w = (seq[i] == P_F) ? wf : wm;
                for (int k = 0; k <= w; k++)
                    one_cycle(seq[i], k == w, op, f3, z, l, lu, 1'b0);
            end else if (seq[i] == P_ILL) begin
`ifdef ILLEGAL_TRAP_EN
                for (int k = 0; k < 4; k++)
                    one_cycle(P_ILL, 1'($urandom), op, f3, z, l, lu, 1'b1);
`else
                one_cycle(P_ILL, 1'($urandom), op, f3, z, l, lu, 1'b0);
`endif
            end else begin
                one_cycle(seq[i], 1'($urandom), op, f3, z, l, lu, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        if (retires) exp_instret = exp_instret + 1'b1;
        checks++;
        if (bus.instret !== exp_instret) begin
            failures++;
            $display("FAIL instret op=%h actual=%0d required=%0d", op, bus.instret, exp_instret);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_add();
        run_instr(7'h33, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mem_waits();
        run_instr(7'h03, 3'd2, 0, 2, 1'b0, 1'b0, 1'b0);
        run_instr(7'h23, 3'd2, 1, 1, 1'b0, 1'b0, 1'b0);
        run_instr(7'h6F, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_branches();
        run_instr(7'h63, 3'd1, 0, 0, 1'b0, 1'b1, 1'b1);
        run_instr(7'h63, 3'd1, 0, 0, 1'b1, 1'b0, 1'b0);
        run_instr(7'h63, 3'd6, 0, 0, 1'b1, 1'b0, 1'b1);
        run_instr(7'h63, 3'd2, 0, 0, 1'b1, 1'b1, 1'b1);
        run_instr(7'h63, 3'd2, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(7'h63, 3'd5, 0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr(7'h00, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        do_reset();
`else
        run_instr(7'h33, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        int top;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h7F};
`ifdef ILLEGAL_TRAP_EN
        top = 7;
`else
        top = 8;
`endif
        for (int n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, top)], 3'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 16; n++)
            run_instr(7'h13, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.instret !== '0) begin
            failures++; $display("FAIL wrap_to_zero actual=%0d required=0", bus.instret);
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] e;
        run_instr(7'h33, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(7'h33, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        one_cycle(P_F, 1'b1, 7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        one_cycle(P_D, 1'b1, 7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        one_cycle(P_MA, 1'b1, 7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        one_cycle(P_MR, 1'b0, 7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        exp_instret = '0;
        #1;
        e = exp_vec(P_F, 1'b0, 7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act_vec() !== e) begin
            failures++; $display("FAIL midreset_outputs actual=%h required=%h", act_vec(), e);
        end
        checks++;
        if (bus.instret !== exp_instret) begin
            failures++; $display("FAIL midreset_instret actual=%0d required=0", bus.instret);
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(7'h37, 3'd0, 1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0; failures = 0; exp_instret = '0;
        rst_n = 1'b1;
        bus.op = 7'h33; bus.funct3 = 3'd0; bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_add();
        test_mem_waits();
        test_branches();
        test_illegal();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the RV32I datapath. It is the sequenced successor to the single-cycle main decoder. It steps each instruction through FETCH/DECODE/execute/writeback states and drives the shared-memory, ALU-source, result-select and write-enable strobes. It also waits on a memory-ready handshake, evaluates all six conditional branches, and keeps a parametrised retired-instruction counter. It sits between the instruction register (op/funct3) and the datapath muxes and enables.

## Interface
- CNT_W, 32, width of retired-instruction counter `instret`
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instruction opcode (IR[6:0])
- funct3  in  3  IR[14:12]
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access in progress
- adrsrc  out  1  0 = PC address, 1 = ALUOut address
- irwrite  out  1  load IR
- pcwrite  out  1  load PC (jump, fetch advance, or taken branch)
- memwrite  out  1  store strobe
- regwrite  out  1  register-file write
- resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alusrca  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- alusrcb  out  2  00 rs2, 01 ImmExt, 10 constant 4
- aluop  out  2  00 add, 01 sub/compare, 10 funct-decoded
- immsrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- instret  out  CNT_W  retired-instruction count
- illegal  out  1  sticky illegal-opcode flag (macro only)

## Operation
- Moore FSM. Unlisted outputs are 0 and don't-care selects are 0. `immsrc` is decoded combinationally from `op` in every state; unknown opcode gives 000.
- FETCH: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
  - irwrite = pcwrite = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alusrca=01, alusrcb=01, aluop=00 (computes branch/jump target). Next state by op:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - 0010111 → AUIPC
  - else → ILLEGAL
- MEMADR: alusrca=10, alusrcb=01. Goes to MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD: mem_req=1, adrsrc=1, resultsrc=00. Holds until mem_ready, then MEMWB.
- MEMWB: resultsrc=01, regwrite=1. Next state FETCH.
- MEMWRITE: mem_req=1, adrsrc=1, memwrite=1, resultsrc=00. Holds until mem_ready, then FETCH. memwrite is held high for the whole wait.
- EXECR: alusrca=10, alusrcb=00, aluop=10. Next state ALUWB.
- EXECI: alusrca=10, alusrcb=01, aluop=10. Next state ALUWB.
- LUI: alusrca=11, alusrcb=01. Next state ALUWB.
- AUIPC: alusrca=01, alusrcb=01. Next state ALUWB.
- ALUWB: resultsrc=00, regwrite=1. Next state FETCH.
- JAL: alusrca=01, alusrcb=10, resultsrc=00, pcwrite=1. Next state ALUWB (writes PC+4 to rd).
- BRANCH: alusrca=10, alusrcb=00, aluop=01, resultsrc=00. Next state FETCH.
  - pcwrite = taken, where taken by funct3 is: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010/011 → 0.
- ILLEGAL: behaviour is set by the macro (see Configuration).
- instret:
  - Increments by 1, modulo 2^CNT_W, on the clock edge leaving MEMWB, ALUWB, BRANCH, or MEMWRITE-with-mem_ready.
  - Wraps from all-ones to 0 with no flag.

## Timing
- Reset (rst_n=0, asynchronous): state=FETCH, instret=0, illegal=0. All write strobes (irwrite, pcwrite, memwrite, regwrite) are forced to 0 while rst_n=0.
- Cycles per instruction with zero-wait memory (mem_ready tied 1):
  - lw 5, sw 4
  - R/I/LUI/AUIPC 4
  - beq-class 3
  - jal 4
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle. State and outputs hold steady while waiting.
- mem_ready is ignored outside the memory states.
- Deasserting rst_n mid-instruction aborts the instruction: instret is not incremented, and the next instruction starts in FETCH after release.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - ILLEGAL asserts illegal=1 (sticky until reset) and stays in ILLEGAL forever.
  - All strobes are 0 in ILLEGAL and instret is frozen.
- ILLEGAL_TRAP_EN undefined:
  - ILLEGAL lasts one cycle with no strobes, then goes to FETCH. The instruction acts as a NOP and is not counted.
  - `illegal` is tied to 0.

## Test plan
- Reset, then add (op=0110011) with mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; regwrite=1 only in cycle 4; instret=1.
- lw with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; adrsrc=1 held through the wait; regwrite in MEMWB only.
- sw with 1 wait cycle → memwrite=1 for 2 cycles; instret increments once, on the mem_ready edge.
- bne (funct3=001): zero=0 gives pcwrite=1 in BRANCH; zero=1 gives pcwrite=0. bltu with ltu=1 → taken. funct3=010 → never taken.
- op=0000000 with ILLEGAL_TRAP_EN → illegal=1 and FSM stuck. Without the macro → back to FETCH after 3 cycles, instret unchanged.
- CNT_W=4, retire 16 instructions → instret wraps to 0. rst_n pulsed low mid-MEMREAD → FETCH immediately, instret=0.
